sram_stream_ctrl: RTL and testbench

//  Clocked, parametrised successor to the 8x64K bench SRAM model. Single-port word memory with a

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_rd_pipe.sv | 35 +++
 rtl/sram_stream_ctrl.sv | 151 +++++++++++++++
 tb/tb_sram_stream_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared dump FSM encodings and region addressing helper
package sram_pkg;

    typedef logic [1:0] dump_state_t;

    localparam dump_state_t ST_IDLE = 2'd0;
    localparam dump_state_t ST_LOAD = 2'd1;
    localparam dump_state_t ST_SEND = 2'd2;
    localparam dump_state_t ST_DONE = 2'd3;

    function automatic int unsigned region_base(input int unsigned num, input int unsigned rsize);
        return num * rsize;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - fixed-latency read data pipe, output holds last valid word
module sram_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];

    // Data stages only load on a valid beat so the final stage keeps the last read word.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= in_valid_i;
            if (in_valid_i) dat_q[0] <= in_data_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_valid_o = vld_q[RD_LAT-1];
    assign out_data_o  = dat_q[RD_LAT-1];

endmodule

// File: rtl/sram_stream_ctrl.sv
// rtl/sram_stream_ctrl.sv - single-port word memory with pipelined reads and region dump streamer
module sram_stream_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 65536,
    parameter int RD_LAT  = 2,
    parameter int REGIONS = 4
) (
    input  logic                                         clk,
    input  logic                                         n_rst,
    input  logic                                         read,
    input  logic                                         write,
    input  logic [ADDR_W-1:0]                            addr,
    input  logic [DATA_W-1:0]                            valueIn,
    output logic [DATA_W-1:0]                            valueOut,
    output logic                                         rdValid,
    output logic                                         addrErr,
    output logic                                         collision,
    input  logic                                         dump,
    input  logic [((REGIONS > 1) ? $clog2(REGIONS) : 1)-1:0] dumpNum,
    output logic [DATA_W-1:0]                            dumpData,
    output logic                                         dumpValid,
    input  logic                                         dumpReady,
    output logic                                         dumpDone,
    output logic                                         busy
);

    localparam int RSIZE = DEPTH / REGIONS;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = (RSIZE > 1) ? $clog2(RSIZE) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    dump_state_t       state_q, state_d;
    logic [IDX_W-1:0]  base_q, base_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic              dump_valid_q, dump_valid_d;
    logic              dump_done_q, dump_done_d;
    logic              busy_q, busy_d;
    logic              addr_err_q, collision_q;

    logic              in_range, dump_start, acc_en, wr_en, rd_acc;
    logic [IDX_W-1:0]  idx, dump_idx;
    logic [DATA_W-1:0] rd_data;

    // A dump request in IDLE takes priority over any access presented in the same cycle.
    assign in_range   = {1'b0, addr} < DEPTH_LIM;
    assign dump_start = (state_q == ST_IDLE) && dump;
    assign acc_en     = !busy_q && !dump_start;
    assign wr_en      = acc_en && write && in_range;
    assign rd_acc     = acc_en && read && !write;
    assign idx        = addr[IDX_W-1:0];
    assign rd_data    = in_range ? mem[idx] : '0;
    assign dump_idx   = base_q + IDX_W'(ptr_q);

    always_ff @(posedge clk) begin
        if (n_rst && wr_en) mem[idx] <= valueIn;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            addr_err_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            addr_err_q  <= acc_en && (read || write) && !in_range;
            collision_q <= acc_en && read && write;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        ptr_d        = ptr_q;
        dump_data_d  = dump_data_q;
        dump_valid_d = dump_valid_q;
        dump_done_d  = 1'b0;
        busy_d       = busy_q;
        case (state_q)
            ST_IDLE: if (dump) begin
                base_d  = IDX_W'(region_base(32'(dumpNum), RSIZE));
                ptr_d   = '0;
                busy_d  = 1'b1;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                dump_data_d  = mem[dump_idx];
                dump_valid_d = 1'b1;
                state_d      = ST_SEND;
            end
            ST_SEND: if (dumpReady) begin
                dump_valid_d = 1'b0;
                if (ptr_q == PTR_W'(RSIZE - 1)) begin
                    dump_done_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    ptr_d   = ptr_q + PTR_W'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            ptr_q        <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            ptr_q        <= ptr_d;
            dump_data_q  <= dump_data_d;
            dump_valid_q <= dump_valid_d;
            dump_done_q  <= dump_done_d;
            busy_q       <= busy_d;
        end
    end

    sram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk         (clk),
        .n_rst       (n_rst),
        .in_valid_i  (rd_acc),
        .in_data_i   (rd_data),
        .out_valid_o (rdValid),
        .out_data_o  (valueOut)
    );

    assign addrErr   = addr_err_q;
    assign collision = collision_q;
    assign dumpData  = dump_data_q;
    assign dumpValid = dump_valid_q;
    assign dumpDone  = dump_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sram_stream_ctrl.sv
// tb/tb_sram_stream_ctrl.sv - directed self-checking bench for sram_stream_ctrl
module tb_sram_stream_ctrl;

    logic        clk = 1'b0;
    logic        n_rst, read, write, dump, dumpReady;
    logic [15:0] addr;
    logic [7:0]  valueIn, valueOut, dumpData;
    logic [1:0]  dumpNum;
    logic        rdValid, addrErr, collision, dumpValid, dumpDone, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_stream_ctrl #(
        .DATA_W  (8),
        .ADDR_W  (16),
        .DEPTH   (256),
        .RD_LAT  (2),
        .REGIONS (4)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .read      (read),
        .write     (write),
        .addr      (addr),
        .valueIn   (valueIn),
        .valueOut  (valueOut),
        .rdValid   (rdValid),
        .addrErr   (addrErr),
        .collision (collision),
        .dump      (dump),
        .dumpNum   (dumpNum),
        .dumpData  (dumpData),
        .dumpValid (dumpValid),
        .dumpReady (dumpReady),
        .dumpDone  (dumpDone),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] v);
        addr = a; valueIn = v; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
        addr = a; read = 1'b1;
        tick();
        read = 1'b0;
        chk({tag, "_early"}, rdValid, 0);
        tick();
        chk({tag, "_valid"}, rdValid, 1);
        chk({tag, "_data"}, valueOut, exp);
    endtask

    task automatic run_dump(input int num, input bit rnd, input int abort_at,
                            output int words, output int dones, output int cycles, output int side);
        dumpNum = num[1:0]; dump = 1'b1;
        tick();
        dump = 1'b0;
        chk("dump_busy_start", busy, 1);
        words = 0; dones = 0; cycles = 0; side = 0;
        while (busy && cycles < 2000 && !(abort_at >= 0 && words == abort_at)) begin
            dumpReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dumpValid && dumpReady) begin
                chk("dump_data", dumpData, num * 64 + words);
                words++;
            end
            if (dumpDone) dones++;
            if (rdValid || addrErr || collision) side++;
            tick();
            cycles++;
        end
        dumpReady = 1'b0;
    endtask

    initial begin
        int words, dones, cycles, side;
        n_rst = 1'b0; read = 1'b0; write = 1'b0; dump = 1'b0; dumpReady = 1'b0;
        addr = '0; valueIn = '0; dumpNum = '0;
        tick(); tick();
        chk("rst_rdValid", rdValid, 0);
        chk("rst_valueOut", valueOut, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dumpValid", dumpValid, 0);
        chk("rst_dumpDone", dumpDone, 0);
        chk("rst_flags", {addrErr, collision}, 0);
        n_rst = 1'b1;
        tick();

        wr(0, 89); wr(59, 210); wr(195, 66);
        rd_chk("rd0", 0, 89);
        rd_chk("rd59", 59, 210);
        rd_chk("rd195", 195, 66);
        tick();
        chk("hold_valid", rdValid, 0);
        chk("hold_data", valueOut, 66);

        addr = 0; read = 1'b1;
        tick();
        addr = 59;
        tick();
        chk("b2b_v0", rdValid, 1);
        chk("b2b_d0", valueOut, 89);
        addr = 195;
        tick();
        read = 1'b0;
        chk("b2b_v1", rdValid, 1);
        chk("b2b_d1", valueOut, 210);
        tick();
        chk("b2b_v2", rdValid, 1);
        chk("b2b_d2", valueOut, 66);
        tick();
        chk("b2b_end", rdValid, 0);

        addr = 59; valueIn = 7; read = 1'b1; write = 1'b1;
        tick();
        read = 1'b0; write = 1'b0;
        chk("coll_pulse", collision, 1);
        chk("coll_nov0", rdValid, 0);
        tick();
        chk("coll_clear", collision, 0);
        chk("coll_nov1", rdValid, 0);
        tick();
        chk("coll_nov2", rdValid, 0);
        rd_chk("coll_rd59", 59, 7);

        wr(44, 123);
        wr(300, 5);
        chk("aerr_wr", addrErr, 1);
        tick();
        chk("aerr_wr_clr", addrErr, 0);
        addr = 300; read = 1'b1;
        tick();
        read = 1'b0;
        chk("aerr_rd", addrErr, 1);
        chk("aerr_rd_early", rdValid, 0);
        tick();
        chk("aerr_rd_valid", rdValid, 1);
        chk("aerr_rd_data", valueOut, 0);
        chk("aerr_rd_clr", addrErr, 0);
        rd_chk("alias44", 44, 123);

        for (int i = 0; i < 256; i++) wr(16'(i), 8'(i));
        tick(); tick();

        addr = 70; valueIn = 8'hEE; write = 1'b1; read = 1'b1;
        run_dump(1, 1'b1, -1, words, dones, cycles, side);
        write = 1'b0; read = 1'b0;
        chk("d1_words", words, 64);
        chk("d1_dones", dones, 1);
        chk("d1_timeout", cycles < 2000, 1);
        chk("d1_side", side, 0);
        chk("d1_busy_end", busy, 0);
        chk("d1_done_end", dumpDone, 0);
        rd_chk("d1_wr_ignored", 70, 70);

        dumpReady = 1'b1;
        run_dump(2, 1'b0, 10, words, dones, cycles, side);
        chk("abort_words", words, 10);
        n_rst = 1'b0;
        tick();
        chk("abort_dumpValid", dumpValid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_dumpDone", dumpDone, 0);
        n_rst = 1'b1;
        tick();
        chk("abort_busy2", busy, 0);
        chk("abort_done2", dumpDone, 0);

        run_dump(3, 1'b0, -1, words, dones, cycles, side);
        chk("d3_words", words, 64);
        chk("d3_dones", dones, 1);
        chk("d3_cycles", cycles, 129);
        chk("d3_busy_end", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
